// File: rtl/axi_qos_addr_arbiter.sv
// axi_qos_addr_arbiter: shares one AXI address channel (AR or AW) between
// four masters. Each master is policed by an outstanding-transaction cap and a
// token bucket counted in data beats. Eligible masters are served
// round-robin.
// Optional build macro QOS_M0_PRIO_EN: master 0, when eligible, wins every
// arbitration slot and does not move the round-robin pointer.
module axi_qos_addr_arbiter #(
    parameter int NUM_M         = 4,
    parameter int ADDR_W        = 32,
    parameter int MAX_OUT       = 16,
    parameter int CREDIT_MAX    = 512,
    parameter int REFILL_AMT    = 16,
    parameter int REFILL_PERIOD = 32
) (
    input  logic                     clk_100MHz,
    input  logic                     reset_rtl_0,
    input  logic [NUM_M-1:0]         req_valid,
    input  logic [NUM_M*ADDR_W-1:0]  req_addr,
    input  logic [NUM_M*8-1:0]       req_len,
    output logic [NUM_M-1:0]         req_ready,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [ADDR_W-1:0]        m_addr,
    output logic [7:0]               m_len,
    output logic [1:0]               m_id,
    input  logic                     done_valid,
    input  logic [1:0]               done_id,
    output logic [NUM_M*16-1:0]      throttle_cnt,
    output logic                     err_underflow
);

    localparam int CREDIT_W = $clog2(CREDIT_MAX + 1);
    localparam int SUM_W    = CREDIT_W + 1;
    localparam int CMP_W    = (SUM_W > 9) ? SUM_W : 9;
    localparam int OUT_W    = $clog2(MAX_OUT + 1);
    localparam int REF_W    = (REFILL_PERIOD > 1) ? $clog2(REFILL_PERIOD) : 1;

    typedef enum logic {ARB, ISSUE} state_t;

    state_t              state_q;
    logic                m_valid_q;
    logic [ADDR_W-1:0]   m_addr_q;
    logic [7:0]          m_len_q;
    logic [1:0]          m_id_q;
    logic [1:0]          last_grant_q;
    logic [CREDIT_W-1:0] credit_q   [NUM_M];
    logic [CREDIT_W-1:0] credit_d   [NUM_M];
    logic [OUT_W-1:0]    out_cnt_q  [NUM_M];
    logic [OUT_W-1:0]    out_cnt_d  [NUM_M];
    logic [15:0]         throttle_q [NUM_M];
    logic [15:0]         throttle_d [NUM_M];
    logic [REF_W-1:0]    refill_cnt_q;
    logic                err_q;

    logic [8:0]          cost       [NUM_M];
    logic [NUM_M-1:0]    elig;
    logic [NUM_M-1:0]    grant_vec;
    logic [1:0]          winner;
    logic [ADDR_W-1:0]   win_addr;
    logic [7:0]          win_len;
    logic                refill_wrap;

    // Per-master beat cost and eligibility against outstanding cap and bucket level.
    always_comb begin
        for (int i = 0; i < NUM_M; i++) begin
            cost[i] = {1'b0, req_len[i*8 +: 8]} + 9'd1;
            elig[i] = req_valid[i]
                   && (out_cnt_q[i] < OUT_W'(MAX_OUT))
                   && (CMP_W'(credit_q[i]) >= CMP_W'(cost[i]));
        end
    end

    // Round-robin winner search starting just after the last granted master.
    always_comb begin
        logic       found;
        logic [1:0] idx;
        found  = 1'b0;
        idx    = 2'd0;
        winner = last_grant_q;
        for (int k = 1; k <= NUM_M; k++) begin
            idx = last_grant_q + 2'(k);
            if (!found && elig[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
`ifdef QOS_M0_PRIO_EN
        if (elig[0]) begin
            winner = 2'd0;
        end
`endif
    end

    // Grant vector and mux of the winning master's address and length.
    always_comb begin
        grant_vec = '0;
        win_addr  = '0;
        win_len   = '0;
        if (state_q == ARB && |elig) begin
            grant_vec = NUM_M'(1) << winner;
        end
        for (int i = 0; i < NUM_M; i++) begin
            if (winner == 2'(i)) begin
                win_addr = req_addr[i*ADDR_W +: ADDR_W];
                win_len  = req_len[i*8 +: 8];
            end
        end
    end

    assign req_ready   = grant_vec & {NUM_M{reset_rtl_0}};
    assign refill_wrap = (refill_cnt_q == REF_W'(REFILL_PERIOD - 1));

    // Next-state bucket level, outstanding count and throttle counter per master.
    always_comb begin
        for (int i = 0; i < NUM_M; i++) begin
            logic [SUM_W-1:0] sum;
            logic             dec;
            sum = SUM_W'(credit_q[i])
                + (refill_wrap  ? SUM_W'(REFILL_AMT) : SUM_W'(0))
                - (grant_vec[i] ? SUM_W'(cost[i])    : SUM_W'(0));
            credit_d[i] = (sum > SUM_W'(CREDIT_MAX)) ? CREDIT_W'(CREDIT_MAX)
                                                      : sum[CREDIT_W-1:0];

            dec = done_valid && (done_id == 2'(i)) && (out_cnt_q[i] != '0);
            out_cnt_d[i] = out_cnt_q[i];
            if (grant_vec[i] && !dec) begin
                out_cnt_d[i] = out_cnt_q[i] + OUT_W'(1);
            end else if (dec && !grant_vec[i]) begin
                out_cnt_d[i] = out_cnt_q[i] - OUT_W'(1);
            end

            throttle_d[i] = throttle_q[i];
            if (state_q == ARB && req_valid[i] && !elig[i] && throttle_q[i] != 16'hFFFF) begin
                throttle_d[i] = throttle_q[i] + 16'd1;
            end
        end
    end

    // Policing state: buckets, outstanding counts, throttle counters, refill timer, underflow flag.
    always_ff @(posedge clk_100MHz or negedge reset_rtl_0) begin
        if (!reset_rtl_0) begin
            for (int i = 0; i < NUM_M; i++) begin
                credit_q[i]   <= CREDIT_W'(CREDIT_MAX);
                out_cnt_q[i]  <= '0;
                throttle_q[i] <= '0;
            end
            refill_cnt_q <= '0;
            err_q        <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_M; i++) begin
                credit_q[i]   <= credit_d[i];
                out_cnt_q[i]  <= out_cnt_d[i];
                throttle_q[i] <= throttle_d[i];
            end
            refill_cnt_q <= refill_wrap ? '0 : refill_cnt_q + REF_W'(1);
            if (done_valid && out_cnt_q[done_id] == '0) begin
                err_q <= 1'b1;
            end
        end
    end

    // Arbitration FSM with registered downstream address outputs.
    always_ff @(posedge clk_100MHz or negedge reset_rtl_0) begin
        if (!reset_rtl_0) begin
            state_q      <= ARB;
            m_valid_q    <= 1'b0;
            m_addr_q     <= '0;
            m_len_q      <= '0;
            m_id_q       <= '0;
            last_grant_q <= 2'(NUM_M - 1);
        end else begin
            case (state_q)
                ARB: begin
                    if (|elig) begin
                        m_valid_q <= 1'b1;
                        m_addr_q  <= win_addr;
                        m_len_q   <= win_len;
                        m_id_q    <= winner;
`ifdef QOS_M0_PRIO_EN
                        if (winner != 2'd0) begin
                            last_grant_q <= winner;
                        end
`else
                        last_grant_q <= winner;
`endif
                        state_q   <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (m_ready) begin
                        m_valid_q <= 1'b0;
                        state_q   <= ARB;
                    end
                end
                default: state_q <= ARB;
            endcase
        end
    end

    assign m_valid       = m_valid_q;
    assign m_addr        = m_addr_q;
    assign m_len         = m_len_q;
    assign m_id          = m_id_q;
    assign err_underflow = err_q;

    for (genvar g = 0; g < NUM_M; g++) begin : g_thr
        assign throttle_cnt[g*16 +: 16] = throttle_q[g];
    end

endmodule

// File: tb/tb_axi_qos_addr_arbiter.sv
// Self-checking bench for axi_qos_addr_arbiter. Expected grants go into a
// scoreboard queue when a scenario is set up; a monitor pops and compares on
// every downstream address handshake. Build with QOS_M0_PRIO_EN defined to
// exercise the master-0 priority variant.
module tb_axi_qos_addr_arbiter;

    localparam int NUM_M  = 4;
    localparam int ADDR_W = 32;

    typedef struct packed {
        logic [1:0]        id;
        logic [ADDR_W-1:0] addr;
        logic [7:0]        len;
    } grant_t;

    logic                    clk_100MHz = 1'b0;
    logic                    reset_rtl_0 = 1'b0;
    logic [NUM_M-1:0]        req_valid = '0;
    logic [NUM_M*ADDR_W-1:0] req_addr = '0;
    logic [NUM_M*8-1:0]      req_len = '0;
    logic [NUM_M-1:0]        req_ready;
    logic                    m_valid;
    logic                    m_ready = 1'b0;
    logic [ADDR_W-1:0]       m_addr;
    logic [7:0]              m_len;
    logic [1:0]              m_id;
    logic                    done_valid = 1'b0;
    logic [1:0]              done_id = '0;
    logic [NUM_M*16-1:0]     throttle_cnt;
    logic                    err_underflow;

    grant_t sbQ[$];
    int     compareCnt = 0;
    int     failCnt = 0;

    axi_qos_addr_arbiter dut (
        .clk_100MHz    (clk_100MHz),
        .reset_rtl_0   (reset_rtl_0),
        .req_valid     (req_valid),
        .req_addr      (req_addr),
        .req_len       (req_len),
        .req_ready     (req_ready),
        .m_valid       (m_valid),
        .m_ready       (m_ready),
        .m_addr        (m_addr),
        .m_len         (m_len),
        .m_id          (m_id),
        .done_valid    (done_valid),
        .done_id       (done_id),
        .throttle_cnt  (throttle_cnt),
        .err_underflow (err_underflow)
    );

    always #5 clk_100MHz = ~clk_100MHz;

    function automatic logic [ADDR_W-1:0] masterAddr(input int id);
        return 32'h4000_0000 + 32'(id) * 32'h100;
    endfunction

    function automatic logic [15:0] thr(input int id);
        return throttle_cnt[id*16 +: 16];
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        compareCnt++;
        if (act !== exp) begin
            failCnt++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic [NUM_M-1:0] valid, input logic [7:0] len);
        req_valid = valid;
        for (int i = 0; i < NUM_M; i++) begin
            req_addr[i*ADDR_W +: ADDR_W] = masterAddr(i);
            req_len[i*8 +: 8]            = len;
        end
    endtask

    task automatic expectGrant(input int id, input logic [7:0] len);
        grant_t g;
        g.id   = 2'(id);
        g.addr = masterAddr(id);
        g.len  = len;
        sbQ.push_back(g);
    endtask

    task automatic resetDut();
        reset_rtl_0 = 1'b0;
        applyStimulus('0, 8'd0);
        done_valid = 1'b0;
        done_id    = '0;
        m_ready    = 1'b1;
        sbQ.delete();
        repeat (2) @(posedge clk_100MHz);
        #1;
    endtask

    // After this returns, the next rising edge is edge 1 of the scenario.
    task automatic releaseReset();
        @(posedge clk_100MHz);
        #1;
        reset_rtl_0 = 1'b1;
    endtask

    // Monitor: every downstream handshake must match the oldest expected grant.
    always @(negedge clk_100MHz) begin
        if (reset_rtl_0 && m_valid && m_ready) begin
            grant_t act;
            act = '{id: m_id, addr: m_addr, len: m_len};
            if (sbQ.size() == 0) begin
                compareCnt++;
                failCnt++;
                $display("[TB] FAIL unexpected_grant: got id %0d addr %0h len %0d expected none",
                         m_id, m_addr, m_len);
            end else begin
                checkOutput("grant", 64'(act), 64'(sbQ.pop_front()));
            end
        end
    end

    initial begin
        // Reset state and single M0 LEN=0 transaction
        resetDut();
        applyStimulus(4'b0001, 8'd0);
        checkOutput("rst_req_ready", 64'(req_ready), 64'd0);
        checkOutput("rst_m_valid", 64'(m_valid), 64'd0);
        checkOutput("rst_m_addr", 64'(m_addr), 64'd0);
        checkOutput("rst_m_len", 64'(m_len), 64'd0);
        checkOutput("rst_m_id", 64'(m_id), 64'd0);
        checkOutput("rst_err", 64'(err_underflow), 64'd0);
        checkOutput("rst_throttle", 64'(throttle_cnt), 64'd0);
        expectGrant(0, 8'd0);
        releaseReset();
        @(negedge clk_100MHz);
        checkOutput("t1_req_ready", 64'(req_ready), 64'b0001);
        checkOutput("t1_m_valid_pre", 64'(m_valid), 64'd0);
        @(posedge clk_100MHz);
        #1;
        applyStimulus('0, 8'd0);
        @(negedge clk_100MHz);
        checkOutput("t1_m_valid", 64'(m_valid), 64'd1);
        checkOutput("t1_m_id", 64'(m_id), 64'd0);
        checkOutput("t1_ready_in_issue", 64'(req_ready), 64'd0);
        repeat (2) @(negedge clk_100MHz);
        checkOutput("t1_idle", 64'(m_valid), 64'd0);
        checkOutput("t1_sb_drained", 64'(sbQ.size()), 64'd0);

        // M1..M3 LEN=127 flood: four grants each, then throttled until refills reach 128 beats
        resetDut();
        applyStimulus(4'b1110, 8'd127);
        for (int r = 0; r < 4; r++) begin
            for (int m = 1; m <= 3; m++) begin
                expectGrant(m, 8'd127);
            end
        end
        expectGrant(1, 8'd127);
        releaseReset();
        repeat (100) @(posedge clk_100MHz);
        @(negedge clk_100MHz);
        checkOutput("t2_starved_ready", 64'(req_ready), 64'd0);
        checkOutput("t2_sb_pending", 64'(sbQ.size()), 64'd1);
        repeat (156) @(posedge clk_100MHz);
        @(negedge clk_100MHz);
        checkOutput("t2_thr_m1", 64'(thr(1)), 64'd234);
        checkOutput("t2_thr_m2", 64'(thr(2)), 64'd233);
        checkOutput("t2_thr_m3", 64'(thr(3)), 64'd232);
        checkOutput("t2_thr_m0", 64'(thr(0)), 64'd0);
        checkOutput("t2_refilled_ready", 64'(req_ready), 64'b0010);
        @(posedge clk_100MHz);
        #1;
        applyStimulus('0, 8'd127);
        repeat (3) @(negedge clk_100MHz);
        checkOutput("t2_sb_drained", 64'(sbQ.size()), 64'd0);

        // M1 LEN=0 flood: 16 outstanding then stall, one completion frees exactly one slot
        resetDut();
        applyStimulus(4'b0010, 8'd0);
        for (int n = 0; n < 17; n++) begin
            expectGrant(1, 8'd0);
        end
        releaseReset();
        repeat (40) @(posedge clk_100MHz);
        #1;
        done_valid = 1'b1;
        done_id    = 2'd1;
        @(negedge clk_100MHz);
        checkOutput("t3_cap_ready", 64'(req_ready), 64'd0);
        checkOutput("t3_cap_thr", 64'(thr(1)), 64'd8);
        checkOutput("t3_cap_sb", 64'(sbQ.size()), 64'd1);
        @(posedge clk_100MHz);
        #1;
        done_valid = 1'b0;
        @(negedge clk_100MHz);
        checkOutput("t3_freed_ready", 64'(req_ready), 64'b0010);
        checkOutput("t3_freed_thr", 64'(thr(1)), 64'd9);
        repeat (9) @(posedge clk_100MHz);
        @(negedge clk_100MHz);
        checkOutput("t3_restall_ready", 64'(req_ready), 64'd0);
        checkOutput("t3_restall_thr", 64'(thr(1)), 64'd16);
        checkOutput("t3_sb_drained", 64'(sbQ.size()), 64'd0);
        checkOutput("t3_no_err", 64'(err_underflow), 64'd0);

        // All four masters LEN=0: round-robin order, or M0 every slot with priority enabled
        resetDut();
        applyStimulus(4'b1111, 8'd0);
`ifdef QOS_M0_PRIO_EN
        for (int n = 0; n < 5; n++) begin
            expectGrant(0, 8'd0);
        end
`else
        expectGrant(0, 8'd0);
        expectGrant(1, 8'd0);
        expectGrant(2, 8'd0);
        expectGrant(3, 8'd0);
        expectGrant(0, 8'd0);
`endif
        releaseReset();
        repeat (9) @(posedge clk_100MHz);
        #1;
        applyStimulus('0, 8'd0);
        repeat (3) @(negedge clk_100MHz);
        checkOutput("t4_sb_drained", 64'(sbQ.size()), 64'd0);
        checkOutput("t4_no_throttle", 64'(throttle_cnt), 64'd0);

        // Completion against an idle master sets the sticky underflow flag
        resetDut();
        releaseReset();
        @(negedge clk_100MHz);
        checkOutput("t5_err_clear", 64'(err_underflow), 64'd0);
        @(posedge clk_100MHz);
        #1;
        done_valid = 1'b1;
        done_id    = 2'd2;
        @(posedge clk_100MHz);
        #1;
        done_valid = 1'b0;
        @(negedge clk_100MHz);
        checkOutput("t5_err_set", 64'(err_underflow), 64'd1);
        repeat (10) @(negedge clk_100MHz);
        checkOutput("t5_err_sticky", 64'(err_underflow), 64'd1);

        // Same-cycle grant and completion on M3 keeps its outstanding count
        resetDut();
        checkOutput("t5_err_reset", 64'(err_underflow), 64'd0);
        applyStimulus(4'b1000, 8'd0);
        for (int n = 0; n < 17; n++) begin
            expectGrant(3, 8'd0);
        end
        releaseReset();
        repeat (30) @(posedge clk_100MHz);
        #1;
        done_valid = 1'b1;
        done_id    = 2'd3;
        @(posedge clk_100MHz);
        #1;
        done_valid = 1'b0;
        repeat (5) @(posedge clk_100MHz);
        @(negedge clk_100MHz);
        checkOutput("t5_m3_stall_ready", 64'(req_ready), 64'd0);
        checkOutput("t5_m3_thr", 64'(thr(3)), 64'd2);
        checkOutput("t5_m3_sb_drained", 64'(sbQ.size()), 64'd0);
        checkOutput("t5_m3_no_err", 64'(err_underflow), 64'd0);
        applyStimulus('0, 8'd0);

        // Reset during ISSUE drops m_valid at once and restores full buckets
        resetDut();
        m_ready = 1'b0;
        applyStimulus(4'b0100, 8'd255);
        releaseReset();
        @(posedge clk_100MHz);
        #1;
        applyStimulus('0, 8'd255);
        @(negedge clk_100MHz);
        checkOutput("t6_issue_valid", 64'(m_valid), 64'd1);
        checkOutput("t6_issue_id", 64'(m_id), 64'd2);
        checkOutput("t6_issue_len", 64'(m_len), 64'd255);
        #2;
        reset_rtl_0 = 1'b0;
        #1;
        checkOutput("t6_async_drop", 64'(m_valid), 64'd0);
        m_ready = 1'b1;
        applyStimulus(4'b0100, 8'd255);
        expectGrant(2, 8'd255);
        expectGrant(2, 8'd255);
        releaseReset();
        repeat (6) @(posedge clk_100MHz);
        @(negedge clk_100MHz);
        checkOutput("t6_bucket_empty_ready", 64'(req_ready), 64'd0);
        checkOutput("t6_thr", 64'(thr(2)), 64'd2);
        checkOutput("t6_sb_drained", 64'(sbQ.size()), 64'd0);
        applyStimulus('0, 8'd0);
        repeat (2) @(posedge clk_100MHz);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCnt, failCnt);
        $finish;
    end

endmodule
